// File: rtl/fifo_byte_unpacker_pkg.sv
// rtl/fifo_byte_unpacker_pkg.sv - shared state encodings for the FIFO byte unpacker
package fifo_byte_unpacker_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_SHIFT = 2'd3;

endpackage

// File: rtl/fifo_byte_unpacker.sv
// rtl/fifo_byte_unpacker.sv - pops words from a non-fallthrough FIFO and streams them out as bytes, LSB first
module fifo_byte_unpacker
  import fifo_byte_unpacker_pkg::*;
#(
  parameter int pDATA_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            byte_count,
  input  logic                   abort,
  input  logic                   fifo_empty,
  output logic                   fifo_ren,
  input  logic [pDATA_WIDTH-1:0] fifo_rdata,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            words_read
);

  localparam int pBYTES = pDATA_WIDTH / 8;
  localparam int pIDX_W = (pBYTES > 1) ? $clog2(pBYTES) : 1;
  localparam logic [pIDX_W-1:0] pLAST_IDX = pIDX_W'(pBYTES - 1);

  logic [1:0]             state;
  logic [31:0]            remaining;
  logic [pDATA_WIDTH-1:0] shreg;
  logic [pIDX_W-1:0]      byte_idx;
  logic                   handshake;

  assign busy      = (state != ST_IDLE);
  assign fifo_ren  = (state == ST_FETCH) && !fifo_empty && !abort;
  assign out_valid = (state == ST_SHIFT);
  assign out_data  = shreg[7:0];
  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      shreg      <= '0;
      byte_idx   <= '0;
      words_read <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      // A byte accepted in the same cycle as abort still counts as sent
      if (handshake) begin
        shreg    <= shreg >> 8;
        byte_idx <= byte_idx + 1'b1;
        if (remaining != '0) remaining <= remaining - 32'd1;
      end
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (byte_count != '0) begin
                remaining  <= byte_count;
                words_read <= '0;
                state      <= ST_FETCH;
              end else begin
                done <= 1'b1;
              end
            end
          end
          ST_FETCH: begin
            if (fifo_ren) begin
              state <= ST_LOAD;
              if (words_read != '1) words_read <= words_read + 32'd1;
            end
          end
          ST_LOAD: begin
            shreg    <= fifo_rdata;
            byte_idx <= '0;
            state    <= ST_SHIFT;
          end
          ST_SHIFT: begin
            // Leftover bytes of the word are dropped once the count is exhausted
            if (handshake) begin
              if (remaining == 32'd1) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end else if (byte_idx == pLAST_IDX) begin
                state <= ST_FETCH;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/fifo_byte_unpacker.md
FIFO_BYTE_UNPACKER -- requirements
Module: fifo_byte_unpacker

Interface
REQ-001 Parameter pDATA_WIDTH, default 64, FIFO word width in bits; SHALL be a multiple of 8, from 8 to 256.
REQ-002 Localparam pBYTES = pDATA_WIDTH/8 SHALL be derived, not user-set.
REQ-003 Ports SHALL be, one per line, with one clock; reset is synchronous and active-high:
  clk  input  1  sole clock, all logic rising-edge
  reset  input  1  synchronous active-high reset
  start  input  1  one-cycle request to stream byte_count bytes
  byte_count  input  32  number of bytes to stream, sampled with start
  abort  input  1  terminate the current transfer
  fifo_empty  input  1  empty flag of upstream non-fallthrough fifo_sync
  fifo_ren  output  1  read strobe to upstream FIFO
  fifo_rdata  input  pDATA_WIDTH  FIFO read data, valid the cycle after fifo_ren
  out_data  output  8  byte stream data
  out_valid  output  1  out_data valid
  out_ready  input  1  downstream accepts byte
  busy  output  1  transfer in progress
  done  output  1  one-cycle completion pulse
  words_read  output  32  FIFO words popped in current/last transfer

Function
REQ-004 States SHALL be IDLE, FETCH, LOAD, SHIFT; busy SHALL equal (state != IDLE).
REQ-005 IDLE: start with byte_count != 0 SHALL latch remaining = byte_count, clear words_read, and go to FETCH; start with byte_count == 0 SHALL pulse done on the next cycle and stay IDLE.
REQ-006 start SHALL be ignored while busy.
REQ-007 fifo_ren SHALL be combinational: (state == FETCH) && !fifo_empty && !abort; it SHALL never assert in any other state, so the upstream FIFO never underflows.
REQ-008 FETCH: when fifo_ren = 1, the next state SHALL be LOAD and words_read SHALL increment; otherwise the block SHALL stay in FETCH indefinitely.
REQ-009 LOAD: fifo_rdata SHALL be captured into the shift register, byte index cleared, next state SHALL be SHIFT.
REQ-010 SHIFT: out_valid SHALL be 1 and out_data SHALL equal shift register bits [7:0], so bytes go out little-endian, byte 0 first.
REQ-011 On out_valid && out_ready: the shift register SHALL shift right 8, remaining SHALL decrement, and the byte index SHALL increment.
REQ-012 If remaining reaches 0 on a handshake, the next state SHALL be IDLE and done SHALL pulse the following cycle; unsent bytes of that word SHALL be discarded.
REQ-013 Otherwise, a handshake on byte index pBYTES-1 SHALL return to FETCH.
REQ-014 out_data/out_valid SHALL hold stable while out_valid && !out_ready.
REQ-015 abort SHALL force IDLE on the next edge from any state, with no done pulse; a word popped in LOAD or SHIFT SHALL be discarded.
REQ-016 abort has priority over start and over a same-cycle final handshake; that final byte counts as sent but done SHALL NOT pulse.
REQ-017 remaining SHALL be 32-bit and never wrap below 0; words_read SHALL saturate at 2^32-1.
REQ-018 Throughput per full word SHALL be pBYTES+2 cycles with out_ready held at 1 and FIFO non-empty.

Reset
REQ-019 reset SHALL force state IDLE, busy 0, done 0, out_valid 0, fifo_ren 0, words_read 0, remaining 0, shift register 0, byte index 0, and out_data 0.
REQ-020 reset mid-transfer SHALL abandon the transfer without a done pulse; the FIFO contents SHALL be untouched beyond words already popped.

Structure
REQ-021 State encodings (2-bit) SHALL live in a shared package/include used by the bench; no typedefs beyond that.
REQ-022 The block SHALL be a single module with no sub-module instances; the upstream fifo_sync is instantiated by the parent, not inside.

Verification
REQ-023 pDATA_WIDTH=32, FIFO preloaded 0x44332211, 0x88776655; start, byte_count=8, out_ready=1 -> bytes 11..88 in order, words_read=2, done one cycle after byte 8.
REQ-024 Same FIFO, byte_count=5 -> bytes 11,22,33,44,55; then IDLE; words_read=2; FIFO now empty.
REQ-025 Empty FIFO, byte_count=4 -> fifo_ren stays 0, block waits in FETCH; push 0xDDCCBBAA after 10 cycles -> AA,BB,CC,DD then done; no FIFO underflow.
REQ-026 Random out_ready backpressure (50%) over 64 bytes -> stream matches model, out_data stable during stalls.
REQ-027 abort asserted during the third byte of a 12-byte transfer -> IDLE next cycle, no done, start accepted again.
REQ-028 reset in SHIFT -> all outputs at reset values next cycle; start with byte_count=0 -> done pulse, busy stays 0.
